// File: rtl/masked_sbox_scheduler.sv
// Round-robin scheduler sharing one first-order (2-share) masked AES S-box between NREQ requesters.
// Optional macro SBOX_SYNCH_HANDSHAKE_EN: EVAL ends on the S-box sync pulse and adds the sbox_timeout output.
module masked_sbox_scheduler #(
  parameter int NREQ     = 2,
  parameter int SBOX_LAT = 2,
  parameter int IDW      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_x_s0,
  input  logic [8*NREQ-1:0] req_x_s1,
  input  logic              rnd_valid,
  output logic              rnd_ready,
  input  logic [7:0]        rnd_data,
  output logic [7:0]        sbox_x_s0,
  output logic [7:0]        sbox_x_s1,
  output logic [7:0]        sbox_fresh,
  input  logic [7:0]        sbox_y_s0,
  input  logic [7:0]        sbox_y_s1,
  input  logic              sbox_synch,
`ifdef SBOX_SYNCH_HANDSHAKE_EN
  output logic              sbox_timeout,
`endif
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [7:0]        rsp_y_s0,
  output logic [7:0]        rsp_y_s1,
  output logic              busy
);

  localparam int CW = $clog2(4*SBOX_LAT+1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RAND = 2'd1;
  localparam logic [1:0] S_EVAL = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]     state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt_id;
  logic [7:0]     hold_s0;
  logic [7:0]     hold_s1;
  logic [CW-1:0]  cnt;
  logic           pick_found;
  logic [IDW-1:0] pick_id;
  logic [7:0]     sel_s0;
  logic [7:0]     sel_s1;
  logic           eval_done;

  // Two passes: first requesters at or above the pointer, then the wrapped-around ones.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!pick_found && req_valid[i] && (IDW'(i) >= ptr)) begin
        pick_found = 1'b1;
        pick_id    = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!pick_found && req_valid[i] && (IDW'(i) < ptr)) begin
        pick_found = 1'b1;
        pick_id    = IDW'(i);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++)
      req_ready[i] = rst && (state == S_IDLE) && pick_found && (pick_id == IDW'(i));
  end

  // Each share gets its own selection mux so the shares never meet in shared logic.
  always_comb begin
    sel_s0 = 8'h00;
    for (int i = 0; i < NREQ; i++)
      if (pick_id == IDW'(i)) sel_s0 = req_x_s0[8*i +: 8];
  end

  always_comb begin
    sel_s1 = 8'h00;
    for (int i = 0; i < NREQ; i++)
      if (pick_id == IDW'(i)) sel_s1 = req_x_s1[8*i +: 8];
  end

`ifdef SBOX_SYNCH_HANDSHAKE_EN
  logic synch_seen;

  assign eval_done = synch_seen;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      synch_seen   <= 1'b0;
      sbox_timeout <= 1'b0;
    end else begin
      if (state != S_EVAL || synch_seen)
        synch_seen <= 1'b0;
      else if (sbox_synch)
        synch_seen <= 1'b1;
      if (state == S_EVAL && !synch_seen && !sbox_synch && cnt == CW'(4*SBOX_LAT))
        sbox_timeout <= 1'b1;
    end
  end
`else
  logic unused_synch;

  assign unused_synch = sbox_synch;
  assign eval_done    = (cnt == CW'(SBOX_LAT));
`endif

  assign rsp_id = gnt_id;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      ptr        <= '0;
      gnt_id     <= '0;
      hold_s0    <= 8'h00;
      hold_s1    <= 8'h00;
      cnt        <= '0;
      sbox_x_s0  <= 8'h00;
      sbox_x_s1  <= 8'h00;
      sbox_fresh <= 8'h00;
      rsp_y_s0   <= 8'h00;
      rsp_y_s1   <= 8'h00;
      rsp_valid  <= 1'b0;
      rnd_ready  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            hold_s0   <= sel_s0;
            hold_s1   <= sel_s1;
            gnt_id    <= pick_id;
            rnd_ready <= 1'b1;
            busy      <= 1'b1;
            state     <= S_RAND;
          end
        end
        S_RAND: begin
          if (rnd_valid) begin
            sbox_x_s0  <= hold_s0;
            sbox_x_s1  <= hold_s1;
            sbox_fresh <= rnd_data;
            cnt        <= '0;
            rnd_ready  <= 1'b0;
            state      <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (cnt != CW'(4*SBOX_LAT))
            cnt <= cnt + 1'b1;
          // Both shares and the randomness drop to zero on the capture edge.
          if (eval_done) begin
            rsp_y_s0   <= sbox_y_s0;
            rsp_y_s1   <= sbox_y_s1;
            sbox_x_s0  <= 8'h00;
            sbox_x_s1  <= 8'h00;
            sbox_fresh <= 8'h00;
            rsp_valid  <= 1'b1;
            state      <= S_RESP;
          end
        end
        default: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_y_s0  <= 8'h00;
            rsp_y_s1  <= 8'h00;
            ptr       <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_masked_sbox_scheduler.sv
// Bench for masked_sbox_scheduler: behavioural masked S-box plus a transaction-level round-robin model.
module tb_masked_sbox_scheduler;
  localparam int NREQ     = 2;
  localparam int SBOX_LAT = 2;
  localparam int IDW      = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_x_s0;
  logic [8*NREQ-1:0] req_x_s1;
  logic              rnd_valid;
  logic              rnd_ready;
  logic [7:0]        rnd_data;
  logic [7:0]        sbox_x_s0;
  logic [7:0]        sbox_x_s1;
  logic [7:0]        sbox_fresh;
  logic [7:0]        sbox_y_s0;
  logic [7:0]        sbox_y_s1;
  logic              sbox_synch;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_y_s0;
  logic [7:0]        rsp_y_s1;
  logic              busy;
`ifdef SBOX_SYNCH_HANDSHAKE_EN
  logic              sbox_timeout;
`endif

  int n_cmp     = 0;
  int n_fail    = 0;
  int model_ptr = 0;

  always #5 clk = ~clk;

  masked_sbox_scheduler #(.NREQ(NREQ), .SBOX_LAT(SBOX_LAT), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x_s0   (req_x_s0),
    .req_x_s1   (req_x_s1),
    .rnd_valid  (rnd_valid),
    .rnd_ready  (rnd_ready),
    .rnd_data   (rnd_data),
    .sbox_x_s0  (sbox_x_s0),
    .sbox_x_s1  (sbox_x_s1),
    .sbox_fresh (sbox_fresh),
    .sbox_y_s0  (sbox_y_s0),
    .sbox_y_s1  (sbox_y_s1),
    .sbox_synch (sbox_synch),
`ifdef SBOX_SYNCH_HANDSHAKE_EN
    .sbox_timeout (sbox_timeout),
`endif
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_y_s0   (rsp_y_s0),
    .rsp_y_s1   (rsp_y_s1),
    .busy       (busy)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1B) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  // AES S-box from its definition: GF(2^8) inverse followed by the affine map.
  function automatic logic [7:0] sbox_fn(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h00;
    for (int c = 1; c < 256; c++)
      if (gmul(a, 8'(c)) == 8'h01) inv = 8'(c);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] mask, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return 0;
  endfunction

  // Masked S-box stand-in with SBOX_LAT=2 register stages; share 1 of the output is the fresh mask.
  logic [7:0] sb_a_p1;
  logic [7:0] sb_f_p1;
  always @(posedge clk) begin
    sb_a_p1   <= sbox_x_s0 ^ sbox_x_s1;
    sb_f_p1   <= sbox_fresh;
    sbox_y_s0 <= sbox_fn(sb_a_p1) ^ sb_f_p1;
    sbox_y_s1 <= sb_f_p1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] val);
    logic [7:0] m;
    m = 8'($urandom);
    req_x_s0[8*i +: 8] = m;
    req_x_s1[8*i +: 8] = m ^ val;
  endtask

  // One full operation driven from an IDLE cycle; the requester is predicted by the round-robin model.
  task automatic run_op(input logic [7:0] r, input int stall, input int bp, input bit drop, input bit churn);
    int gid;
    int k;
    int n_edges;
    logic [7:0] x0;
    logic [7:0] x1;
    logic [NREQ-1:0] oh;
    logic [18:0] rsp_snap;
    gid = rr_pick(req_valid, model_ptr);
    oh  = NREQ'(1) << gid;
    x0  = req_x_s0[8*gid +: 8];
    x1  = req_x_s1[8*gid +: 8];
    rnd_data  = r;
    rnd_valid = (stall == 0);
    rsp_ready = (bp == 0);
    #1;
    check("grant", 32'(req_ready), 32'(oh));
    tick();
    if (drop) req_valid[gid] = 1'b0;
    check("rand_ctrl", 32'({busy, rnd_ready, req_ready}), 32'({1'b1, 1'b1, {NREQ{1'b0}}}));
    check("rand_bus_zero", 32'({sbox_x_s0, sbox_x_s1, sbox_fresh}), 32'h0);
    for (int s = 0; s < stall; s++) begin
      tick();
      check("stall_bus_zero", 32'({sbox_x_s0, sbox_x_s1, sbox_fresh, rnd_ready}), 32'h1);
    end
    rnd_valid = 1'b1;
    tick();
    rnd_valid = 1'b0;
    rnd_data  = 8'($urandom);
    check("eval_load", 32'({sbox_x_s0, sbox_x_s1, sbox_fresh}), 32'({x0, x1, r}));
    n_edges = 2 + stall;
    k = 0;
    while (rsp_valid !== 1'b1 && k < 20) begin
      if (churn) req_valid = NREQ'($urandom);
      tick();
      k++;
      n_edges++;
      if (rsp_valid !== 1'b1)
        check("eval_hold", 32'({sbox_x_s0, sbox_x_s1, sbox_fresh}), 32'({x0, x1, r}));
    end
    check("rsp_valid_seen", 32'(rsp_valid), 32'h1);
    check("latency", 32'(n_edges), 32'(SBOX_LAT + 3 + stall));
    check("rsp_id", 32'(rsp_id), 32'(gid));
    check("rsp_unmasked", 32'(rsp_y_s0 ^ rsp_y_s1), 32'(sbox_fn(x0 ^ x1)));
    check("rsp_mask_share", 32'(rsp_y_s1), 32'(r));
    check("bus_zeroed", 32'({sbox_x_s0, sbox_x_s1, sbox_fresh}), 32'h0);
    rsp_snap = {rsp_id, rsp_y_s0, rsp_y_s1};
    for (int b = 0; b < bp; b++) begin
      tick();
      #1;
      check("bp_hold", 32'({rsp_valid, rsp_id, rsp_y_s0, rsp_y_s1}), 32'({1'b1, rsp_snap}));
      check("bp_no_grant", 32'(req_ready), 32'h0);
    end
    rsp_ready = 1'b1;
    tick();
    check("rsp_clear", 32'({rsp_valid, rsp_y_s0, rsp_y_s1}), 32'h0);
    model_ptr = (gid + 1) % NREQ;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NREQ-1:0] m;
    logic            any_rsp;
    rst        = 1'b0;
    req_valid  = '0;
    req_x_s0   = '0;
    req_x_s1   = '0;
    rnd_valid  = 1'b0;
    rnd_data   = 8'h00;
    sbox_synch = 1'b0;
    rsp_ready  = 1'b1;
    tick();
    tick();
    check("reset_outputs", 32'({rsp_valid, rnd_ready, busy, req_ready, rsp_id}), 32'h0);
    check("reset_data", 32'({sbox_x_s0, sbox_x_s1, sbox_fresh}), 32'h0);
    check("reset_rsp_y", 32'({rsp_y_s0, rsp_y_s1}), 32'h0);
    rst = 1'b1;
    tick();
    check("idle_after_reset", 32'({busy, rnd_ready, rsp_valid}), 32'h0);

    // Basic: value 0x00 (shares A5/A5) -> 0x63.
    req_x_s0[7:0] = 8'hA5;
    req_x_s1[7:0] = 8'hA5;
    req_valid = 2'b01;
    run_op(8'h3C, 0, 0, 1'b1, 1'b0);

    // Randomness stall of six cycles on requester 1.
    set_req(1, 8'h00);
    req_valid = 2'b10;
    run_op(8'($urandom), 6, 0, 1'b1, 1'b0);

    // Fairness: both requesters held valid.
    set_req(0, 8'h53);
    set_req(1, 8'h01);
    req_valid = 2'b11;
    for (int t = 0; t < 4; t++)
      run_op(8'($urandom), 0, 0, 1'b0, 1'b0);

    // Backpressure with requester 1 pending, then requester 1 served immediately.
    set_req(0, 8'($urandom));
    set_req(1, 8'($urandom));
    req_valid = 2'b11;
    run_op(8'($urandom), 0, 10, 1'b1, 1'b0);
    run_op(8'($urandom), 0, 0, 1'b1, 1'b0);

    // Move the pointer to 1, then abandon an operation by reset during EVAL cycle 1.
    set_req(0, 8'($urandom));
    req_valid = 2'b01;
    run_op(8'($urandom), 0, 0, 1'b1, 1'b0);
    set_req(1, 8'($urandom));
    req_valid = 2'b10;
    rnd_valid = 1'b1;
    rnd_data  = 8'h5A;
    tick();
    tick();
    rnd_valid = 1'b0;
    tick();
    #2 rst = 1'b0;
    #1;
    check("midreset_ctrl", 32'({rsp_valid, rnd_ready, busy, req_ready, rsp_id}), 32'h0);
    check("midreset_data", 32'({sbox_x_s0, sbox_x_s1, sbox_fresh, rsp_y_s0, rsp_y_s1}), 32'h0);
    req_valid = '0;
    tick();
    rst = 1'b1;
    model_ptr = 0;
    any_rsp = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      any_rsp = any_rsp | rsp_valid | busy;
    end
    check("no_rsp_after_reset", 32'(any_rsp), 32'h0);
    set_req(0, 8'($urandom));
    set_req(1, 8'($urandom));
    req_valid = 2'b11;
    run_op(8'($urandom), 0, 0, 1'b1, 1'b0);

    // Randomized operations with request churn, randomness stalls and backpressure.
    for (int t = 0; t < 24; t++) begin
      m = NREQ'($urandom);
      if (m == '0) begin
        req_valid = '0;
        tick();
        check("idle_no_req", 32'({busy, rnd_ready}), 32'h0);
        m = NREQ'(1) << $urandom_range(0, NREQ-1);
      end
      for (int i = 0; i < NREQ; i++)
        if (m[i]) set_req(i, 8'($urandom));
      req_valid = m;
      run_op(8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 1'b1, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/masked_sbox_scheduler.md
Name: masked_sbox_scheduler

Overview:
- Sequencer and arbiter that shares one first-order (2-share) masked AES S-box instance between NREQ requesters, e.g. the state datapath and the key schedule.
- Per operation it grants one requester round-robin and obtains 8 fresh random bits from the PRNG.
- It holds S-box inputs and randomness stable for the full evaluation latency, captures both output shares, and returns them tagged with the requester id.
- It zeroes the S-box input and randomness buses between operations so that shares of consecutive operations never transition into each other.

Parameters:
- NREQ, 2, number of requesters (2..8).
- SBOX_LAT, 2, cycles from stable S-box inputs to valid S-box outputs.
- IDW, 3, width of rsp_id; must satisfy 2^IDW >= NREQ.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request.
- req_ready  out  NREQ  per-requester grant; one-hot or zero.
- req_x_s0  in  8*NREQ  share 0 of the input byte; requester i drives bits [8i+7:8i].
- req_x_s1  in  8*NREQ  share 1 of the input byte, same packing.
- rnd_valid  in  1  PRNG data valid.
- rnd_ready  out  1  PRNG data consumed.
- rnd_data  in  8  fresh randomness.
- sbox_x_s0  out  8  S-box input share 0.
- sbox_x_s1  out  8  S-box input share 1.
- sbox_fresh  out  8  S-box fresh randomness.
- sbox_y_s0  in  8  S-box output share 0.
- sbox_y_s1  in  8  S-box output share 1.
- sbox_synch  in  1  S-box gating-controller sync pulse; used only with the optional feature.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accepted.
- rsp_id  out  IDW  index of the requester the response belongs to.
- rsp_y_s0  out  8  result share 0.
- rsp_y_s1  out  8  result share 1.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE and the round-robin pointer to 0.
  - All capture registers clear, so sbox_x_s0/s1, sbox_fresh, rsp_y_s0/s1 and rsp_id read 0.
  - rsp_valid, rnd_ready, req_ready and busy read 0.
  - Reset mid-operation abandons the operation; no response is issued for it.
- All S-box-facing and response outputs come from registers. Only req_ready is combinational.

- IDLE:
  - req_ready[i]=1 only for the requester selected by the round-robin search, which starts at the pointer and wraps from NREQ-1 to 0.
  - On handshake, capture that requester's two shares into the hold registers (not yet driven to the S-box), record its id, and go to RAND.
  - No request present: stay in IDLE.
- RAND:
  - rnd_ready=1.
  - When rnd_valid=1, capture rnd_data, load the hold registers onto sbox_x_s0/s1 and sbox_fresh in the same edge, clear the counter to 0, and go to EVAL.
  - rnd_valid=0: stay in RAND, with the S-box buses held at 0.
- EVAL:
  - sbox_x_s0/s1 and sbox_fresh stay constant throughout.
  - The counter increments each cycle.
  - In the cycle where counter==SBOX_LAT: capture sbox_y_s0/s1 into rsp_y_s0/s1, clear sbox_x_s0/s1 and sbox_fresh to 0 on the same edge, and go to RESP.
  - Inputs are therefore stable for SBOX_LAT+1 cycles.
- RESP:
  - rsp_valid=1; rsp_id and rsp_y_s0/s1 are held.
  - When rsp_ready=1: clear rsp_valid and rsp_y_s0/s1 to 0, set the pointer to (granted id+1) mod NREQ, and go to IDLE.
  - Backpressure on rsp_ready holds RESP indefinitely; no new grant is given meanwhile.
- Latency:
  - Minimum from request handshake to rsp_valid is SBOX_LAT+3 cycles, with rnd_valid tied high and rsp_ready tied high.
  - Throughput is one operation per SBOX_LAT+4 cycles.
- Other rules:
  - Requests that are withdrawn before grant are not captured.
  - req_x values are sampled only at the handshake edge.
  - The two shares never share a register, adder or mux.
  - Zeroing is applied to both shares in the same edge.

Optional Feature:
- Macro: SBOX_SYNCH_HANDSHAKE_EN.
- When defined:
  - EVAL ignores the counter and instead waits for sbox_synch=1; outputs are captured in the cycle after sbox_synch is seen high.
  - A watchdog sticky bit is set if the counter reaches 4*SBOX_LAT without sbox_synch; it is exposed on an extra output, sbox_timeout (1 bit, cleared only by reset).
- When undefined: sbox_synch is unused and the fixed SBOX_LAT count applies; there is no sbox_timeout port.

Test Plan:
- Basic operation:
  - Setup: NREQ=2, SBOX_LAT=2, bench wires the masked S-box.
  - Stimulus: requester 0 sends s0=0xA5, s1=0xA5 (value 0x00), with rnd_data=0x3C.
  - Required response: rsp_id=0 and rsp_y_s0^rsp_y_s1=0x63, with rsp_valid exactly 5 cycles after the handshake.
- Round-robin fairness:
  - Stimulus: both requesters held valid continuously, with values 0x53 (req0) and 0x01 (req1).
  - Required response: grants alternate 0,1,0,1; unmasked results are 0xED and 0x7C respectively.
- Randomness stall:
  - Stimulus: rnd_valid low for 6 cycles after grant.
  - Required response: S-box buses stay 0 until rnd_valid; rsp_valid appears 6 cycles later than the basic case; result is unchanged.
- Response backpressure:
  - Stimulus: rsp_ready low for 10 cycles, with req1 pending.
  - Required response: rsp outputs stable, req_ready=0; req1 is granted in the cycle after rsp_ready.
- Mid-operation reset:
  - Stimulus: assert rst=0 in EVAL cycle 1.
  - Required response: all outputs 0 immediately (asynchronous); no rsp_valid after release; next request is served with pointer 0.
- SBOX_SYNCH_HANDSHAKE_EN:
  - sbox_synch pulsed at EVAL cycle 3 -> capture follows the pulse.
  - sbox_synch tied 0 -> sbox_timeout=1 after 8 EVAL cycles.
